// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: stage-side and bus-side signals of the IF/MEM memory bus arbiter.
interface mem_bus_arbiter_if;
  logic        flush, if_req, if_done, dm_req, dm_wr, dm_done;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be, bus_be;
  logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok, bus_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        IF_Stall, MEM_Stall;
  modport master (
    input  flush, if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, dm_be,
           bus_addr_ok, bus_data_ok, bus_rdata,
    output if_rdata, if_done, dm_rdata, dm_done, bus_req, bus_wr, bus_addr,
           bus_wdata, bus_be, IF_Stall, MEM_Stall, bus_err
  );
  modport slave (
    output flush, if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, dm_be,
           bus_addr_ok, bus_data_ok, bus_rdata,
    input  if_rdata, if_done, dm_rdata, dm_done, bus_req, bus_wr, bus_addr,
           bus_wdata, bus_be, IF_Stall, MEM_Stall, bus_err
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one SRAM-like bus between IF fetch and MEM data access.
// Define ARB_TIMEOUT_EN to add the REQ/WAIT watchdog that drives bus_err.
module mem_bus_arbiter #(
  parameter int MAX_DM_RUN = 4
`ifdef ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic              clk,
  input  logic              rst,
  mem_bus_arbiter_if.master b
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;
  localparam int RW = $clog2(MAX_DM_RUN + 1);
  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic [RW-1:0] run_q, run_d;
  logic          wr_q, wr_d, sup_q, sup_d, to_q, to_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0]   if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic          grant_dm, grant_if, if_flush, fin, abort, timeout, to_hit, busy, done;
  assign busy     = state_q == REQ || state_q == WAIT;
  assign grant_dm = state_q == IDLE && b.dm_req && (!b.if_req || run_q != RW'(MAX_DM_RUN));
  assign grant_if = state_q == IDLE && b.if_req && !grant_dm;
  assign if_flush = b.flush && !owner_q;
  assign fin      = b.bus_data_ok && (state_q == WAIT || (state_q == REQ && b.bus_addr_ok));
  assign abort    = state_q == REQ && if_flush && !b.bus_addr_ok;
  assign to_hit   = timeout && !fin && !abort;
  assign done     = fin || to_hit;
`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else      cnt_q <= busy ? cnt_q + 1'b1 : '0;
  // Fires on the cycle the count would reach the limit, so RESP lands TIMEOUT_CYCLES after REQ entry.
  assign timeout = busy && cnt_q == CW'(TIMEOUT_CYCLES - 1);
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      run_q      <= '0;
      wr_q       <= 1'b0;
      be_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      sup_q      <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      run_q      <= run_d;
      wr_q       <= wr_d;
      be_q       <= be_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      sup_q      <= sup_d;
      to_q       <= to_d;
    end
  always_comb begin
    owner_d    = owner_q;
    run_d      = run_q;
    wr_d       = wr_q;
    be_d       = be_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    sup_d      = busy ? sup_q || if_flush : sup_q;
    to_d       = to_hit;
    if_rdata_d = done && !owner_q ? (to_hit ? '0 : b.bus_rdata) : if_rdata_q;
    dm_rdata_d = done && owner_q ? (to_hit ? '0 : b.bus_rdata) : dm_rdata_q;
    if (grant_dm || grant_if) begin
      owner_d = grant_dm;
      wr_d    = grant_dm && b.dm_wr;
      be_d    = grant_dm ? b.dm_be : 4'hF;
      addr_d  = grant_dm ? b.dm_addr : b.if_addr;
      wdata_d = grant_dm ? b.dm_wdata : '0;
      sup_d   = 1'b0;
      // A DM grant with IF waiting can only happen below the limit, so the increment saturates.
      run_d   = grant_if || !b.if_req ? '0 : run_q + 1'b1;
    end
    unique case (state_q)
      IDLE:    state_d = grant_dm || grant_if ? REQ : IDLE;
      REQ:     state_d = abort ? IDLE : done ? RESP : b.bus_addr_ok ? WAIT : REQ;
      WAIT:    state_d = done ? RESP : WAIT;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    b.bus_req   = state_q == REQ;
    b.bus_wr    = wr_q;
    b.bus_be    = be_q;
    b.bus_addr  = addr_q;
    b.bus_wdata = wdata_q;
    b.if_done   = state_q == RESP && !owner_q && !sup_q;
    b.dm_done   = state_q == RESP && owner_q;
    b.bus_err   = state_q == RESP && to_q;
    b.if_rdata  = if_rdata_q;
    b.dm_rdata  = dm_rdata_q;
    b.IF_Stall  = b.if_req && !(state_q == RESP && !owner_q && !sup_q);
    b.MEM_Stall = b.dm_req && !(state_q == RESP && owner_q);
  end
endmodule
